// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter
//
// Shares one memory port between the core's instruction-fetch channel and
// its data channel. Accepted requests are remembered, in issue order, in a
// small owner FIFO (one bit per request: 0 = inst, 1 = data). Responses from
// memory are in order, so the FIFO head always names the channel that owns
// the next response. The data channel normally wins arbitration. After
// STARVE_LIMIT consecutive data grants with a fetch waiting, one fetch is
// forced through.
//
// Ports
//   clk, resetn                  clock, asynchronous active-low reset
//   inst_req/inst_addr           fetch request in (read only)
//   inst_addr_ok                 fetch accepted this cycle (combinational)
//   inst_data_ok/inst_rdata      fetch response (registered, 1-cycle pulse)
//   data_req/wr/wstrb/addr/wdata data request in
//   data_addr_ok                 data accepted this cycle (combinational)
//   data_data_ok/data_rdata      data response (registered, 1-cycle pulse)
//   mem_req/wr/wstrb/addr/wdata  request to memory
//   mem_gnt                      memory takes the request this cycle
//   mem_rvalid/mem_rdata         in-order response from memory
//   err                          sticky: response arrived with nothing in flight

module cpu_mem_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        err
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    logic [MAX_OUTSTANDING-1:0] owner_mem_q, owner_mem_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [STV_W-1:0]           starve_cnt_q, starve_cnt_d;
    logic                       err_q, err_d;
    logic                       inst_data_ok_q, inst_data_ok_d;
    logic                       data_data_ok_q, data_data_ok_d;
    logic [31:0]                inst_rdata_q, inst_rdata_d;
    logic [31:0]                data_rdata_q, data_rdata_d;

    logic   full, empty, sel_data, sel_inst, accept, push, pop;
    owner_e head_owner;

    // ------------------------------------------------------------------
    // Arbitration and request path (fully combinational)
    // ------------------------------------------------------------------
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // Data wins unless a waiting fetch has been passed over too often.
    assign sel_data = data_req & ~((starve_cnt_q == STARVE_MAX) & inst_req);
    assign sel_inst = ~sel_data & inst_req;

    // Gated by resetn so no request escapes while the FIFO is being flushed.
    assign mem_req      = (inst_req | data_req) & ~full & resetn;
    assign accept       = mem_req & mem_gnt;
    assign inst_addr_ok = accept & sel_inst;
    assign data_addr_ok = accept & sel_data;

    assign push       = accept;
    assign pop        = mem_rvalid & ~empty;
    assign head_owner = owner_e'(owner_mem_q[rd_ptr_q]);

    always_comb begin
        mem_wr    = 1'b0;
        mem_wstrb = 4'h0;
        mem_addr  = inst_addr;
        mem_wdata = 32'h0;
        if (sel_data) begin
            mem_wr    = data_wr;
            mem_wstrb = data_wstrb;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through
        // this block leaves one unassigned, which would infer a latch.
        owner_mem_d    = owner_mem_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        starve_cnt_d   = starve_cnt_q;
        err_d          = err_q | (mem_rvalid & empty);
        inst_data_ok_d = 1'b0;
        data_data_ok_d = 1'b0;
        inst_rdata_d   = inst_rdata_q;
        data_rdata_d   = data_rdata_q;

        if (push) begin
            owner_mem_d[wr_ptr_q] = sel_data;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);   // wraps: depth is a power of two
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (head_owner == OWN_DATA) begin
                data_data_ok_d = 1'b1;
                data_rdata_d   = mem_rdata;
            end else begin
                inst_data_ok_d = 1'b1;
                inst_rdata_d   = mem_rdata;
            end
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Counts data grants that overtook a waiting fetch; saturates.
        if (!inst_req || (accept && sel_inst)) begin
            starve_cnt_d = '0;
        end else if (accept && sel_data && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + STV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            starve_cnt_q   <= '0;
            err_q          <= 1'b0;
            inst_data_ok_q <= 1'b0;
            data_data_ok_q <= 1'b0;
            inst_rdata_q   <= 32'h0;
            data_rdata_q   <= 32'h0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of every other flop, independent of ordering.
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            starve_cnt_q   <= starve_cnt_d;
            err_q          <= err_d;
            inst_data_ok_q <= inst_data_ok_d;
            data_data_ok_q <= data_data_ok_d;
            inst_rdata_q   <= inst_rdata_d;
            data_rdata_q   <= data_rdata_d;
        end
    end

    // NOTE: the owner storage is deliberately left out of reset; an entry is
    // only ever read after it was written, because count gates every pop.
    always_ff @(posedge clk) begin
        owner_mem_q <= owner_mem_d;
    end

    assign inst_data_ok = inst_data_ok_q;
    assign data_data_ok = data_data_ok_q;
    assign inst_rdata   = inst_rdata_q;
    assign data_rdata   = data_rdata_q;
    assign err          = err_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Scoreboard bench for cpu_mem_arbiter. A stimulus task drives one cycle,
// checks the combinational request path against a queue-based reference
// model and pushes expected responses; an independent monitor pops them and
// compares whenever the cycle they are due arrives.

module tb_cpu_mem_arbiter;

    localparam int MAXO = 4;
    localparam int SLIM = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0, data_wr = 1'b0;
    logic [3:0]  data_wstrb = '0;
    logic [31:0] data_addr = '0, data_wdata = '0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        err;

    cpu_mem_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SLIM)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          owner;   // 1 = data
        logic [31:0] data;
        int          due;
    } exp_t;

    bit          in_flight[$];     // owners of accepted, unanswered requests
    exp_t        exp_q[$];
    int          m_starve = 0;
    bit          m_err = 1'b0;
    logic [31:0] last_i = '0, last_d = '0;
    bit          mon_en = 1'b0;

    // Observed request-path values of the most recent step.
    bit act_mreq, act_iok, act_dok;
    bit exp_iok, exp_dok;

    // One clock cycle: drive at negedge, check the request path, update the model.
    task automatic step(input bit ir, input logic [31:0] ia,
                        input bit dr, input bit dw, input logic [3:0] ds,
                        input logic [31:0] da, input logic [31:0] dd,
                        input bit gnt, input bit rv, input logic [31:0] rd);
        bit full, empty, pick_data, pick_inst, want, acc;
        @(negedge clk);
        inst_req = ir;  inst_addr = ia;
        data_req = dr;  data_wr = dw; data_wstrb = ds; data_addr = da; data_wdata = dd;
        mem_gnt = gnt;  mem_rvalid = rv; mem_rdata = rd;
        #1;
        full      = (in_flight.size() == MAXO);
        empty     = (in_flight.size() == 0);
        pick_data = dr && !(m_starve == SLIM && ir);
        pick_inst = !pick_data && ir;
        want      = (ir || dr) && !full;
        acc       = want && gnt;
        exp_iok   = acc && pick_inst;
        exp_dok   = acc && pick_data;
        act_mreq  = mem_req;
        act_iok   = inst_addr_ok;
        act_dok   = data_addr_ok;

        check("mem_req", {31'b0, mem_req}, {31'b0, want});
        check("inst_addr_ok", {31'b0, inst_addr_ok}, {31'b0, exp_iok});
        check("data_addr_ok", {31'b0, data_addr_ok}, {31'b0, exp_dok});
        check("err", {31'b0, err}, {31'b0, m_err});
        if (want) begin
            check("mem_addr", mem_addr, pick_data ? da : ia);
            check("mem_wr", {31'b0, mem_wr}, {31'b0, pick_data && dw});
            check("mem_wstrb", {28'b0, mem_wstrb}, pick_data ? {28'b0, ds} : 32'h0);
            check("mem_wdata", mem_wdata, pick_data ? dd : 32'h0);
        end

        if (rv) begin
            if (empty) m_err = 1'b1;
            else begin
                exp_t e;
                e.owner = in_flight.pop_front();
                e.data  = rd;
                e.due   = cyc + 1;
                exp_q.push_back(e);
            end
        end
        if (acc) in_flight.push_back(pick_data);

        if (!ir || exp_iok) m_starve = 0;
        else if (exp_dok && m_starve < SLIM) m_starve++;
    endtask

    task automatic idle(input bit rv, input logic [31:0] rd);
        step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, rv, rd);
    endtask

    task automatic drain();
        while (in_flight.size() > 0) idle(1'b1, $urandom);
        idle(1'b0, 32'h0);
        idle(1'b0, 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req"}, {31'b0, mem_req}, 32'h0);
        check({tag, "_inst_addr_ok"}, {31'b0, inst_addr_ok}, 32'h0);
        check({tag, "_data_addr_ok"}, {31'b0, data_addr_ok}, 32'h0);
        check({tag, "_inst_data_ok"}, {31'b0, inst_data_ok}, 32'h0);
        check({tag, "_data_data_ok"}, {31'b0, data_data_ok}, 32'h0);
        check({tag, "_inst_rdata"}, inst_rdata, 32'h0);
        check({tag, "_data_rdata"}, data_rdata, 32'h0);
        check({tag, "_err"}, {31'b0, err}, 32'h0);
    endtask

    // Asynchronous reset asserted between clock edges with requests pending.
    task automatic mid_reset();
        @(negedge clk);
        inst_req = 1'b1; data_req = 1'b1; mem_gnt = 1'b1; mem_rvalid = 1'b0;
        #2 resetn = 1'b0;
        #1 check_reset_outputs("async_rst");
        in_flight.delete();
        exp_q.delete();
        m_starve = 0; m_err = 1'b0; last_i = '0; last_d = '0;
        @(negedge clk);
        inst_req = 1'b0; data_req = 1'b0; mem_gnt = 1'b0;
        #2 resetn = 1'b1;
    endtask

    // ---------------- response monitor ----------------
    always @(negedge clk) begin
        if (mon_en && resetn) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_inst_data_ok", {31'b0, inst_data_ok}, {31'b0, !e.owner});
                check("rsp_data_data_ok", {31'b0, data_data_ok}, {31'b0, e.owner});
                if (e.owner) last_d = e.data;
                else         last_i = e.data;
            end else begin
                check("idle_inst_data_ok", {31'b0, inst_data_ok}, 32'h0);
                check("idle_data_data_ok", {31'b0, data_data_ok}, 32'h0);
            end
            check("inst_rdata", inst_rdata, last_i);
            check("data_rdata", data_rdata, last_d);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit          i_pend, d_pend;
        bit          ir, dr, dw;
        logic [31:0] ia, da, dd;
        logic [3:0]  ds;

        inst_req = 1'b1; data_req = 1'b1; mem_gnt = 1'b1;
        #12 check_reset_outputs("por");
        inst_req = 1'b0; data_req = 1'b0; mem_gnt = 1'b0;
        @(negedge clk);
        #2 resetn = 1'b1;
        mon_en = 1'b1;

        // Back-to-back fetches with in-order responses.
        step(1, 32'h1c000000, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h0);
        check("b2b_iok0", {31'b0, act_iok}, 32'h1);
        step(1, 32'h1c000004, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h0);
        check("b2b_iok1", {31'b0, act_iok}, 32'h1);
        idle(1'b1, 32'h02800c0c);
        idle(1'b1, 32'h02800d0d);
        idle(1'b0, 32'h0);
        check("b2b_last_inst", inst_rdata, 32'h02800d0d);
        idle(1'b0, 32'h0);

        // Simultaneous requests: data first, then the fetch.
        step(1, 32'h1c000008, 1, 0, 4'hf, 32'h80, 32'h0, 1, 0, 32'h0);
        check("simul_data_first", {30'b0, act_dok, act_iok}, 32'h2);
        step(1, 32'h1c000008, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h0);
        check("simul_inst_next", {30'b0, act_dok, act_iok}, 32'h1);
        idle(1'b1, 32'hAAAA0000);
        idle(1'b1, 32'hBBBB0000);
        idle(1'b0, 32'h0);
        check("simul_data_rdata", data_rdata, 32'hAAAA0000);
        check("simul_inst_rdata", inst_rdata, 32'hBBBB0000);

        // Store payload and response.
        step(0, 32'h0, 1, 1, 4'h3, 32'h100, 32'h1234, 1, 0, 32'h0);
        check("store_dok", {31'b0, act_dok}, 32'h1);
        idle(1'b1, 32'h0000_5a5a);
        idle(1'b0, 32'h0);

        // Full: four accepted, fifth waits until the cycle after the pop.
        for (int i = 0; i < MAXO; i++)
            step(0, 32'h0, 1, 0, 4'hf, 32'h200 + 4 * i, 32'h0, 1, 0, 32'h0);
        step(0, 32'h0, 1, 0, 4'hf, 32'h240, 32'h0, 1, 0, 32'h0);
        check("full_blocks", {31'b0, act_mreq}, 32'h0);
        step(0, 32'h0, 1, 0, 4'hf, 32'h240, 32'h0, 1, 1, 32'h11110000);
        check("full_no_push_on_pop", {31'b0, act_dok}, 32'h0);
        step(0, 32'h0, 1, 0, 4'hf, 32'h240, 32'h0, 1, 0, 32'h0);
        check("full_resume", {31'b0, act_dok}, 32'h1);
        drain();

        // Starvation: four data grants, then one forced fetch, repeating.
        for (int i = 0; i < 15; i++) begin
            step(1, 32'h1c000300, 1, 0, 4'hf, 32'h300, 32'h0, 1, in_flight.size() > 0, $urandom);
            check("starve_iok", {31'b0, act_iok}, (i % 5 == 4) ? 32'h1 : 32'h0);
        end
        drain();

        // Randomized traffic obeying the hold rule.
        i_pend = 0; d_pend = 0;
        ir = 0; dr = 0; dw = 0; ia = '0; da = '0; dd = '0; ds = '0;
        for (int n = 0; n < 3000; n++) begin
            if (!i_pend) begin
                ir = ($urandom_range(0, 99) < 60);
                ia = $urandom & 32'hffff_fffc;
                i_pend = ir;
            end
            if (!d_pend) begin
                dr = ($urandom_range(0, 99) < 55);
                dw = $urandom_range(0, 1);
                ds = 4'($urandom);
                da = $urandom;
                dd = $urandom;
                d_pend = dr;
            end
            step(ir, ia, dr, dw, ds, da, dd, $urandom_range(0, 99) < 70,
                 (in_flight.size() > 0) && ($urandom_range(0, 99) < 60), $urandom);
            if (exp_iok) i_pend = 0;
            if (exp_dok) d_pend = 0;
        end
        drain();

        // Protocol error: response with nothing in flight.
        idle(1'b1, 32'hdead_beef);
        idle(1'b0, 32'h0);
        check("err_sticky", {31'b0, err}, 32'h1);

        // Reset with two requests outstanding.
        step(1, 32'h1c000400, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h0);
        step(0, 32'h0, 1, 0, 4'hf, 32'h404, 32'h0, 1, 0, 32'h0);
        mid_reset();
        // Flushed FIFO: a fresh set of MAXO requests fits, the next does not.
        for (int i = 0; i < MAXO; i++)
            step(0, 32'h0, 1, 0, 4'hf, 32'h500 + 4 * i, 32'h0, 1, 0, 32'h0);
        check("post_rst_capacity", {31'b0, act_dok}, 32'h1);
        step(0, 32'h0, 1, 0, 4'hf, 32'h540, 32'h0, 1, 0, 32'h0);
        check("post_rst_full", {31'b0, act_mreq}, 32'h0);
        mid_reset();
        idle(1'b1, 32'hcafe_f00d);   // in-flight responses were discarded
        idle(1'b0, 32'h0);
        check("post_rst_err", {31'b0, err}, 32'h1);
        idle(1'b0, 32'h0);

        check("all_responses_seen", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_mem_arbiter.md
# cpu_mem_arbiter

Arbitrates the core's instruction-fetch and data-access request channels onto a single shared memory port. Tracks up to MAX_OUTSTANDING in-flight requests, in issue order, and routes each in-order memory response back to the channel that issued it. Sits directly downstream of `mycpu_top`, consuming its instruction and data memory requests, and upstream of the memory/bus bridge.

## Interface
Parameters:
- MAX_OUTSTANDING, 4: maximum accepted-but-unanswered requests; a power of two, 2..16.
- STARVE_LIMIT, 4: number of consecutive data grants, with inst_req pending, after which one inst grant is forced.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- inst_req  input  1  instruction-fetch request valid.
- inst_addr  input  32  fetch address (read only).
- inst_addr_ok  output  1  fetch request accepted this cycle.
- inst_data_ok  output  1  fetch response valid (one-cycle pulse).
- inst_rdata  output  32  fetch response data.
- data_req  input  1  data request valid.
- data_wr  input  1  1 = store, 0 = load.
- data_wstrb  input  4  byte enables for a store.
- data_addr  input  32  data address.
- data_wdata  input  32  store data.
- data_addr_ok  output  1  data request accepted this cycle.
- data_data_ok  output  1  data response valid (pulse); issued for loads and stores.
- data_rdata  output  32  load response data.
- mem_req  output  1  request to memory.
- mem_wr, mem_wstrb[3:0], mem_addr[31:0], mem_wdata[31:0]  output  request payload.
- mem_gnt  input  1  memory accepts the request this cycle.
- mem_rvalid  input  1  in-order response valid; one response per accepted request, including stores.
- mem_rdata  input  32  response data.
- err  output  1  sticky protocol error flag.

## Operation
- **Owner FIFO:** MAX_OUTSTANDING entries, 1 bit each (0 = inst, 1 = data), with a count register of width log2(MAX_OUTSTANDING)+1. `full` means count == MAX_OUTSTANDING. `empty` means count == 0.
- **Selection:** data is chosen when data_req=1 and NOT (starve_cnt == STARVE_LIMIT and inst_req=1). Otherwise inst is chosen when inst_req=1.
- **Request drive:**
  - mem_req = (inst_req | data_req) & ~full.
  - The payload comes from the selected channel.
  - For an inst request: mem_wr=0, mem_wstrb=0, mem_wdata=0.
- **Accept:** a request is accepted when mem_req & mem_gnt.
  - Only the selected channel's addr_ok is asserted, combinationally, in the same cycle.
  - The owner bit is pushed into the FIFO.
- **Full:** no push is allowed while full, even if a pop happens in the same cycle. Acceptance resumes the cycle after count drops.
- **Response:** on mem_rvalid with the FIFO not empty:
  - The head entry is popped.
  - The registered response goes to the owner in the next cycle: owner data_ok=1, owner rdata=mem_rdata.
  - The other channel's data_ok stays 0, and its rdata holds its previous value.
- **Simultaneous push and pop:** count is unchanged, and both pointers advance.
- **Pointer wrap:** read and write pointers wrap modulo MAX_OUTSTANDING.
- **Protocol error:** mem_rvalid while empty sets err=1 until reset. No pop occurs and no data_ok is issued.
- **starve_cnt (saturating at STARVE_LIMIT):**
  - Increments on each data accept while inst_req=1.
  - Clears on an inst accept, or on any cycle with inst_req=0.
  - Holds otherwise.
- **Reset mid-operation:** the FIFO is flushed and in-flight responses are discarded. mem_rvalid arriving after reset is treated as an error.

## Timing
- **Reset values:** count=0, pointers=0, starve_cnt=0, err=0, inst_data_ok=0, data_data_ok=0, inst_rdata=0, data_rdata=0.
- **Held low during reset:** while resetn=0, mem_req, inst_addr_ok and data_addr_ok are held 0.
- **Request path:** combinational; addr_ok appears in the same cycle as mem_gnt.
- **Response latency:** exactly 1 cycle from mem_rvalid to data_ok.
- **Throughput:** one accept and one response per cycle, sustained.
- **Input hold rule:** CPU-side inputs must remain stable while req=1 and addr_ok=0. The block does not check this.

## Test plan
- **Back-to-back fetches:** inst_req=1 with addr 0x1c000000, 0x1c000004, mem_gnt=1 every cycle, then mem_rvalid in cycles 3 and 4 with rdata 0x02800c0c, 0x02800d0d.
  - inst_addr_ok in cycles 1 and 2.
  - inst_data_ok in cycles 4 and 5 with the matching data.
  - data_data_ok stays 0.
- **Simultaneous requests:** inst_req and data_req both high in one cycle, with a load at 0x80.
  - Data is granted first; inst is granted the next cycle.
  - Responses 0xAAAA0000 then 0xBBBB0000 return to data then inst respectively.
- **Full:** mem_gnt=1 with no responses, 4 data requests accepted, 5th request pending.
  - mem_req=0 while full.
  - After one mem_rvalid, the 5th request is accepted in the cycle after the pop.
- **Starvation:** data_req and inst_req held high continuously.
  - Exactly 4 data grants, then 1 inst grant, repeating.
  - starve_cnt returns to 0 after each inst grant.
- **Store response:** store to 0x100 with wstrb=0x3 and wdata=0x1234.
  - The mem payload matches the request.
  - data_data_ok is pulsed one cycle after mem_rvalid.
- **Error and reset:** mem_rvalid with the FIFO empty sets err=1, with no data_ok issued. Then resetn is asserted low mid-stream with 2 requests outstanding.
  - All outputs return to their reset values asynchronously.
  - count=0 after reset is released.
